aes_inv_key_expansion: RTL
==========================

# aes_inv_key_expansion

Reverse-direction AES-128 key schedule. Given the final (round-10) round key, the block walks the schedule backwards one round per step and rebuilds all 11 round keys, ending with the original cipher key. It sits beside `key_expansion` in the decryption path. Its `exp_key` output uses the identical 1408-bit layout, so downstream round logic can consume either block's output unchanged.

## Interface
- No parameters. Sizes are fixed constants from `aes_pkg`.
- `clk` in 1 — single clock; all state updates on the rising edge.
- `n_rst` in 1 — synchronous, active-low reset, sampled on the rising edge of `clk`.
- `start_inv_exp` in 1 — start request; honoured only in IDLE or DONE.
- `last_key` in 128 — round-10 key; sampled only on the accepting edge.
- `key_expanded` out 1 — level signal. High when `exp_key` holds a complete schedule.
- `exp_key` out 1408 — round keys.
  - Round r occupies bits `[1407-128r -: 128]`.
  - So round 0 (original key) is in `[1407:1280]` and round 10 is in `[127:0]`.
- `orig_key` out 128 — copy of the round-0 slot; valid when `key_expanded` is high.

## Operation
- States:
  - IDLE: entered from reset.
  - EXPAND
  - DONE
- Reset (`n_rst`=0 at an edge):
  - State goes to IDLE.
  - `exp_key`, `orig_key`, the working register, `round_cnt` and the Rcon register all go to 0.
  - `key_expanded` goes to 0.
  - Reset wins over any simultaneous start and aborts an expansion in progress.
- Accept (IDLE or DONE, `start_inv_exp`=1):
  - Load `last_key` into the round-10 slot and into the working register.
  - Clear the other 10 slots and `orig_key`.
  - Set `round_cnt` to 10 and Rcon to `8'h36`.
  - Clear `key_expanded` and go to EXPAND.
- Backward step. The working words w0..w3 are round r, with w0 in the most-significant bits. Compute:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon,24'h0}
  - RotWord rotates left by one byte.
- At step completion:
  - Write p0..p3 to slot r-1 and into the working register.
  - Decrement `round_cnt`.
  - Update Rcon to its predecessor: `36→1b→80→40→20→10→08→04→02→01`. Use the `aes_pkg` table, indexed by `round_cnt`.
- When slot 0 is written:
  - Copy it to `orig_key`.
  - Set `key_expanded`=1 and go to DONE.
- `start_inv_exp` during EXPAND is ignored; the current run completes.
- DONE holds all outputs stable until a new accept or reset. A restart from DONE clears `key_expanded` on the accepting edge.
- `last_key` changing outside the accepting edge has no effect.

## Timing
- Parallel build:
  - One backward step per cycle.
  - The accepting edge is edge A. Slot 9 is written at A+1, and slot 0 plus `key_expanded` at A+10.
- Serial-S-box build: 4 cycles per step, so `key_expanded` rises at A+40.
- Slot r-1 becomes visible on `exp_key` at the edge completing its step. Partial schedules are observable mid-run.
- `key_expanded` is held high for as long as the block stays in DONE.

## Configuration
- Macro `INV_KEY_EXP_SERIAL_SBOX_EN`.
- Undefined:
  - Four `aes_sbox` instances compute SubWord combinationally.
  - One step per cycle, latency 10.
- Defined:
  - A single `aes_sbox` instance is time-shared.
  - A 2-bit sub-counter selects byte 0..3 of RotWord(p3) and accumulates the results into a 32-bit temp register.
  - The step commits on the edge where the sub-counter equals 3. Latency is 40.
  - The sub-counter resets to 0 on reset and on accept.
- Outputs and final values are identical in both builds.

## Structure
- `aes_pkg` holds:
  - `AES_KEY_W`=128, `AES_NR`=10, `EXP_KEY_W`=1408.
  - The 11-entry Rcon table.
  - The state enum type.
- Sub-module `aes_sbox`: combinational 8-bit forward S-box lookup, shared with `key_expansion`.
- Everything else (FSM, working register, slot writes) lives in `aes_inv_key_expansion`.

## Test plan
- Reset: hold `n_rst`=0 for 2 edges.
  - Expect `key_expanded`=0, `exp_key`=0, `orig_key`=0.
- Standard vector: `last_key`=`13111d7fe3944a17f307a78b4d2b30c5`, pulse start for one cycle.
  - At A+10 (A+40 in the serial build), `orig_key`=`000102030405060708090a0b0c0d0e0f`.
  - `exp_key` equals the full 1408-bit FIPS-197 schedule for that key.
  - Slot 9 at A+1 = `549932d1f08557681093ed9cbe2c974e`.
- Second vector: `last_key`=`28fddef86da4244accc0a4fe3b316f26`.
  - Expect `orig_key`=`5468617473206D79204B756E67204675`.
  - Slot 1 = `E232FCF191129188B159E4E6D679A293`.
- Start while busy: assert start with a different `last_key` at A+4.
  - The first run finishes with an unchanged result and the new key is ignored.
- Restart from DONE: apply vector 2, then vector 1.
  - `key_expanded` drops on the accepting edge and rises again with the correct vector-1 result.
- Mid-run reset: drive `n_rst`=0 at A+5.
  - All outputs are 0 next edge and the state is IDLE.
  - A later start completes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 key-schedule sizes, the Rcon table indexed by round and the expansion FSM state type.
package aes_pkg;
    localparam int AES_KEY_W = 128;
    localparam int AES_NR = 10;
    localparam int EXP_KEY_W = 1408;
    // Entry r is the Rcon used when stepping from round r down to round r-1.
    localparam logic [7:0] RCON_TAB [AES_NR+1] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;
endpackage

// File: rtl/aes_inv_key_expansion_if.sv
// aes_inv_key_expansion_if: start/key request and expanded-schedule response bundle.
interface aes_inv_key_expansion_if;
    import aes_pkg::*;
    logic                 start_inv_exp;
    logic [AES_KEY_W-1:0] last_key;
    logic                 key_expanded;
    logic [EXP_KEY_W-1:0] exp_key;
    logic [AES_KEY_W-1:0] orig_key;
    modport master (output start_inv_exp, last_key, input key_expanded, exp_key, orig_key);
    modport slave (input start_inv_exp, last_key, output key_expanded, exp_key, orig_key);
endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup; entry 0 sits in the top byte of the table.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign out_o = SBOX[{~in_i, 3'b000} +: 8];
endmodule

// File: rtl/aes_inv_key_expansion.sv
// aes_inv_key_expansion: rebuilds the AES-128 schedule backwards from the round-10 key.
// Define INV_KEY_EXP_SERIAL_SBOX_EN to time-share one S-box (4 cycles per round step).
module aes_inv_key_expansion
    import aes_pkg::*;
(
    input logic                    clk,
    input logic                    n_rst,
    aes_inv_key_expansion_if.slave bus
);
    state_e               state_q, state_d;
    logic [AES_KEY_W-1:0] work_q, work_d, orig_q, orig_d, step_key;
    logic [EXP_KEY_W-1:0] exp_q, exp_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           rcon_q, rcon_d;
    logic                 done_q, done_d;
    logic [31:0]          w0, w1, w2, w3, p3, rot, sub_word;
    logic [10:0]          slot_lsb;
    logic                 step_en, accept;

    assign {w0, w1, w2, w3} = work_q;
    assign p3 = w3 ^ w2;
    assign rot = {p3[23:0], p3[31:24]};
    assign step_key = {w0 ^ sub_word ^ {rcon_q, 24'h0}, w1 ^ w0, w2 ^ w1, p3};
    // Slot r-1 starts at bit 128*(11-r) for the current round r.
    assign slot_lsb = {4'd11 - cnt_q, 7'd0};
    assign accept = bus.start_inv_exp && (state_q != EXPAND);

`ifdef INV_KEY_EXP_SERIAL_SBOX_EN
    logic [1:0]  sub_q, sub_d;
    logic [31:0] temp_q, temp_d;
    logic [7:0]  sbox_out;

    aes_sbox u_sbox (.in_i(rot[{~sub_q, 3'b000} +: 8]), .out_o(sbox_out));

    always_comb begin
        temp_d = temp_q;
        temp_d[{~sub_q, 3'b000} +: 8] = sbox_out;
    end

    assign sub_d = sub_q + 2'd1;
    assign sub_word = temp_d;
    assign step_en = &sub_q;

    always_ff @(posedge clk) begin
        if (!n_rst || accept) begin
            sub_q <= '0;
            temp_q <= '0;
        end else if (state_q == EXPAND) begin
            sub_q <= sub_d;
            temp_q <= temp_d;
        end
    end
`else
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.in_i(rot[8*i +: 8]), .out_o(sub_word[8*i +: 8]));
    end
    assign step_en = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        work_d = work_q;
        exp_d = exp_q;
        orig_d = orig_q;
        cnt_d = cnt_q;
        rcon_d = rcon_q;
        done_d = done_q;
        if (accept) begin
            state_d = EXPAND;
            work_d = bus.last_key;
            exp_d = EXP_KEY_W'(bus.last_key);
            orig_d = '0;
            cnt_d = 4'(AES_NR);
            rcon_d = RCON_TAB[AES_NR];
            done_d = 1'b0;
        end else if (state_q == EXPAND && step_en) begin
            work_d = step_key;
            exp_d[slot_lsb +: AES_KEY_W] = step_key;
            cnt_d = cnt_q - 4'd1;
            rcon_d = RCON_TAB[cnt_q - 4'd1];
            orig_d = (cnt_q == 4'd1) ? step_key : orig_q;
            done_d = (cnt_q == 4'd1);
            state_d = (cnt_q == 4'd1) ? DONE : EXPAND;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            work_q <= '0;
            exp_q <= '0;
            orig_q <= '0;
            cnt_q <= '0;
            rcon_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q <= work_d;
            exp_q <= exp_d;
            orig_q <= orig_d;
            cnt_q <= cnt_d;
            rcon_q <= rcon_d;
            done_q <= done_d;
        end
    end

    assign bus.key_expanded = done_q;
    assign bus.exp_key = exp_q;
    assign bus.orig_key = orig_q;
endmodule
